// File: rtl/pipeline_hazard_controller_if.sv
// Bundle of decode-side inputs and pipeline-control outputs for the hazard controller.
// The controller takes the slave view; the driver of decode/memory status takes the master view.
interface pipeline_hazard_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic [19:0]          id_instruction;
    logic                 id_valid;
    logic                 mem_busy;
    logic                 pc_enable;
    logic                 ifid_enable;
    logic                 idex_bubble;
    logic                 pipe_advance;
    logic                 wb_write_enable;
    logic [3:0]           wb_write_address;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] stall_events;
    logic                 dbg_state;

    modport master (
        output id_instruction, id_valid, mem_busy,
        input  pc_enable, ifid_enable, idex_bubble, pipe_advance,
        input  wb_write_enable, wb_write_address, stall_cycles, stall_events, dbg_state
    );

    modport slave (
        input  id_instruction, id_valid, mem_busy,
        output pc_enable, ifid_enable, idex_bubble, pipe_advance,
        output wb_write_enable, wb_write_address, stall_cycles, stall_events, dbg_state
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// RAW hazard detection against writers in EX/MEM/WB, pipeline enables, write-back control
// and saturating stall counters for the 5-stage 20-bit pipeline.
module pipeline_hazard_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    pipeline_hazard_controller_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
    } sb_entry_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               state;
    sb_entry_t            sb_ex, sb_mem, sb_wb;
    logic [CNT_WIDTH-1:0] cycles_q, events_q;

    logic [3:0] opcode, rd, src_a, src_b;
    logic       is_store, is_writer, hazard, advance;

    function automatic logic reads_dest(sb_entry_t e, logic [3:0] a, logic [3:0] b);
        return e.valid && ((e.dest == a) || (e.dest == b));
    endfunction

    always_comb begin
        opcode   = bus.id_instruction[19:16];
        rd       = bus.id_instruction[15:12];
        is_store = (opcode == 4'b1100);
        // Stores read their data register from the rd field.
        src_a    = is_store ? bus.id_instruction[15:12] : bus.id_instruction[11:8];
        src_b    = is_store ? bus.id_instruction[11:8]  : bus.id_instruction[7:4];
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD, 4'hE, 4'hF: is_writer = 1'b1;
            default:                                        is_writer = 1'b0;
        endcase
        hazard  = bus.id_valid && (reads_dest(sb_ex, src_a, src_b) ||
                                   reads_dest(sb_mem, src_a, src_b) ||
                                   reads_dest(sb_wb, src_a, src_b));
        advance = !bus.mem_busy;
    end

    // Reset forces every enable off and a bubble into ID/EX, independent of the inputs.
    assign bus.pc_enable        = reset && !hazard && advance;
    assign bus.ifid_enable      = reset && !hazard && advance;
    assign bus.idex_bubble      = !reset || hazard || !bus.id_valid;
    assign bus.pipe_advance     = reset && advance;
    assign bus.wb_write_enable  = reset && sb_wb.valid && advance;
    assign bus.wb_write_address = reset ? sb_wb.dest : 4'h0;
    assign bus.stall_cycles     = cycles_q;
    assign bus.stall_events     = events_q;
    assign bus.dbg_state        = (state == STALL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            sb_ex    <= '0;
            sb_mem   <= '0;
            sb_wb    <= '0;
            cycles_q <= '0;
            events_q <= '0;
        end else if (advance) begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            sb_ex  <= {is_writer && bus.id_valid && !hazard, rd};
            if (hazard) begin
                state <= STALL;
                if (cycles_q != CNT_MAX) cycles_q <= cycles_q + CNT_ONE;
                if ((state == RUN) && (events_q != CNT_MAX)) events_q <= events_q + CNT_ONE;
            end else begin
                state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios plus random instruction streams against an
// in-flight-register model; a 2-bit-counter instance shares the inputs for saturation.
module tb_pipeline_hazard_controller;
    localparam int CW  = 16;
    localparam int CWS = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipeline_hazard_controller_if #(.CNT_WIDTH(CW))  bus ();
    pipeline_hazard_controller_if #(.CNT_WIDTH(CWS)) bus_s ();

    pipeline_hazard_controller #(.CNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pipeline_hazard_controller #(.CNT_WIDTH(CWS)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    logic [19:0] drv_ins   = 20'h0;
    logic        drv_valid = 1'b0;
    logic        drv_busy  = 1'b0;

    assign bus.id_instruction   = drv_ins;
    assign bus.id_valid         = drv_valid;
    assign bus.mem_busy         = drv_busy;
    assign bus_s.id_instruction = drv_ins;
    assign bus_s.id_valid       = drv_valid;
    assign bus_s.mem_busy       = drv_busy;

    // Reference model: destinations of writers in flight (index 0 = youngest), -1 = none.
    int         flight[3];
    int         m_cycles, m_events;
    bit         m_prev_haz, m_haz, m_load;
    logic [3:0] exp_q[$];
    int         n_checks = 0, n_errors = 0;
    int         low_cnt = 0, wb_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD, 4'hE, 4'hF};
    endfunction

    function automatic bit in_flight(input logic [3:0] r);
        for (int i = 0; i < 3; i++)
            if (flight[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) flight[i] = -1;
        m_cycles = 0; m_events = 0; m_prev_haz = 0; m_haz = 0; m_load = 0;
        exp_q.delete();
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        logic [3:0] op, s1, s2, e;
        bit exp_pc, exp_we;
        @(negedge clock);
        if (!reset) begin
            check("rst_pc", bus.pc_enable, 0);
            check("rst_ifid", bus.ifid_enable, 0);
            check("rst_bubble", bus.idex_bubble, 1);
            check("rst_adv", bus.pipe_advance, 0);
            check("rst_we", bus.wb_write_enable, 0);
            check("rst_addr", bus.wb_write_address, 0);
            check("rst_cycles", bus.stall_cycles, 0);
            check("rst_events", bus.stall_events, 0);
            check("rst_state", bus.dbg_state, 0);
            check("rst_cycles_s", bus_s.stall_cycles, 0);
            @(posedge clock);
            m_load = 0;
            #1;
            return;
        end
        op = drv_ins[19:16];
        s1 = (op == 4'hC) ? drv_ins[15:12] : drv_ins[11:8];
        s2 = (op == 4'hC) ? drv_ins[11:8]  : drv_ins[7:4];
        m_haz  = drv_valid && (in_flight(s1) || in_flight(s2));
        exp_pc = !m_haz && !drv_busy;
        exp_we = (flight[2] >= 0) && !drv_busy;
        check("pc_enable", bus.pc_enable, exp_pc);
        check("ifid_enable", bus.ifid_enable, exp_pc);
        check("idex_bubble", bus.idex_bubble, m_haz || !drv_valid);
        check("pipe_advance", bus.pipe_advance, !drv_busy);
        check("wb_we", bus.wb_write_enable, exp_we);
        check("stall_cycles", bus.stall_cycles, sat(m_cycles, 65535));
        check("stall_events", bus.stall_events, sat(m_events, 65535));
        check("state", bus.dbg_state, m_prev_haz);
        check("stall_cycles_s", bus_s.stall_cycles, sat(m_cycles, 3));
        check("stall_events_s", bus_s.stall_events, sat(m_events, 3));
        if (exp_we) begin
            if (exp_q.size() == 0) check("wb_queue_empty", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("wb_addr", bus.wb_write_address, e);
            end
        end
        if (!bus.pc_enable) low_cnt++;
        if (bus.wb_write_enable) wb_cnt++;
        @(posedge clock);
        if (!drv_busy) begin
            if (m_haz) begin
                m_cycles++;
                if (!m_prev_haz) m_events++;
            end
            m_prev_haz = m_haz;
            flight[2] = flight[1];
            flight[1] = flight[0];
            if (drv_valid && writes(op) && !m_haz) begin
                flight[0] = int'(drv_ins[15:12]);
                exp_q.push_back(drv_ins[15:12]);
            end else begin
                flight[0] = -1;
            end
        end
        m_load = !m_haz && !drv_busy;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_clear();
        repeat (n) step();
        reset = 1'b1;
        low_cnt = 0;
        wb_cnt  = 0;
    endtask

    task automatic issue(input logic [19:0] ins);
        drv_ins   = ins;
        drv_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (m_load) return;
        end
        check("issue_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        drv_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        model_clear();
        // Reset with a live instruction presented in ID.
        drv_ins = 20'h03120; drv_valid = 1'b1; drv_busy = 1'b0;
        do_reset(3);
        step();
        check("rel_pc", low_cnt, 0);
        idle(4);

        // Back-to-back dependent writer/reader.
        do_reset(1);
        issue(20'h03120);
        issue(20'h04300);
        idle(4);
        check("raw_pc_low", low_cnt, 3);
        check("raw_cycles", bus.stall_cycles, 3);
        check("raw_events", bus.stall_events, 1);
        check("raw_wb_cnt", wb_cnt, 2);

        // Independent stream.
        do_reset(1);
        issue(20'h03120);
        issue(20'h14560);
        idle(4);
        check("ind_cycles", bus.stall_cycles, 0);
        check("ind_wb_cnt", wb_cnt, 2);

        // Store reads rd and ra.
        do_reset(1);
        issue(20'h05120);
        issue(20'hC5700);
        idle(4);
        check("st_dep_cycles", bus.stall_cycles, 3);
        do_reset(1);
        issue(20'h05120);
        issue(20'hC7800);
        idle(4);
        check("st_ind_cycles", bus.stall_cycles, 0);
        check("st_wb_cnt", wb_cnt, 1);

        // Freeze in the middle of a stall.
        do_reset(1);
        issue(20'h03120);
        drv_ins = 20'h04300; drv_valid = 1'b1;
        step(); step();
        drv_busy = 1'b1;
        repeat (4) step();
        check("frz_cycles", bus.stall_cycles, 2);
        drv_busy = 1'b0;
        issue(20'h04300);
        idle(4);
        check("frz_total", bus.stall_cycles, 3);
        check("frz_events", bus.stall_events, 1);

        // Two stall runs push the 2-bit counter past its ceiling.
        do_reset(1);
        issue(20'h03120);
        issue(20'h04300);
        issue(20'h05400);
        idle(4);
        check("sat_small", bus_s.stall_cycles, 3);
        check("sat_big", bus.stall_cycles, 6);
        check("sat_events", bus_s.stall_events, 2);

        // Reset with writers in flight and a write-back pending.
        do_reset(1);
        issue(20'h03120);
        issue(20'h14560);
        idle(1);
        #2 reset = 1'b0;
        #1;
        check("mid_we", bus.wb_write_enable, 0);
        check("mid_addr", bus.wb_write_address, 0);
        model_clear();
        step();
        reset = 1'b1;
        wb_cnt = 0;
        idle(4);
        check("mid_wb_cnt", wb_cnt, 0);

        // Random streams with small register range to provoke hazards.
        do_reset(1);
        for (int it = 0; it < 400; it++) begin
            if (it == 200) do_reset(2);
            if (m_load || !drv_valid) begin
                drv_valid = ($urandom_range(0, 9) != 0);
                drv_ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                           4'($urandom_range(0, 15))};
            end
            drv_busy = ($urandom_range(0, 7) == 0);
            step();
        end
        drv_busy = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequences the 5-stage 20-bit pipeline (IF, ID, EX, MEM, WB) by detecting read-after-write hazards between the instruction in ID and writers still in flight in EX/MEM/WB. It stalls IF/ID and inserts bubbles into ID/EX until the hazard clears, and honours a global memory-busy freeze. It also drives register-file write-back control and counts stall cycles and stall events for performance monitoring. It sits beside instruction decode and owns every pipeline-register enable.

## Interface

- CNT_WIDTH, 16, width of the stall-cycle and stall-event counters
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- id_instruction  input  20  instruction currently held in IF/ID; opcode [19:16], rd [15:12], ra [11:8], rb [7:4]
- id_valid  input  1  IF/ID holds a real instruction (0 = bubble)
- mem_busy  input  1  data memory not ready; freezes whole pipeline
- pc_enable  output  1  PC may advance
- ifid_enable  output  1  IF/ID register may load
- idex_bubble  output  1  ID/EX loads a NOP instead of the decoded instruction
- pipe_advance  output  1  EX/MEM and MEM/WB registers may load
- wb_write_enable  output  1  register file write strobe
- wb_write_address  output  4  register file write address
- stall_cycles  output  CNT_WIDTH  saturating count of hazard-stall cycles
- stall_events  output  CNT_WIDTH  saturating count of RUN->STALL transitions

## Operation

- Source decode: opcode 1100 (store) reads [15:12] and [11:8]; every other opcode reads [11:8] and [7:4].
- Writer decode: opcodes 0000, 0001, 0010, 0011, 1011, 1101, 1110, 1111 write rd = [15:12]. Opcode 1100 and 0100-1010 write nothing.
- Scoreboard: three entries EX, MEM, WB, each {valid, dest[3:0]}. Valid means the entry is a writer.
- hazard = id_valid and (either source equals dest of any valid scoreboard entry). No forwarding exists. Register file writes on the edge that retires WB, so a WB match is still a hazard. R0 is an ordinary register and is compared like any other.
- Combinational outputs:
  - pc_enable = ifid_enable = !hazard and !mem_busy.
  - idex_bubble = hazard or !id_valid.
  - pipe_advance = !mem_busy.
  - wb_write_enable = WB.valid and !mem_busy.
  - wb_write_address = WB.dest.
- Scoreboard update on an edge with !mem_busy:
  - WB <= MEM, MEM <= EX.
  - EX <= {writer(id) and id_valid and !hazard, rd}.
  - On a bubble, EX.valid = 0.
- With mem_busy = 1 the scoreboard, state and counters hold, and all enables are 0 (idex_bubble still reflects hazard).
- FSM (registered): RUN, STALL.
  - RUN -> STALL when hazard and !mem_busy.
  - STALL -> RUN when !hazard and !mem_busy.
  - Otherwise hold.
- stall_events increments on each RUN->STALL edge. stall_cycles increments on every edge with hazard and !mem_busy. Both saturate at all-ones.

## Timing

- Reset asserted (low): scoreboard invalid, dest = 0, state = RUN, counters = 0. Outputs are forced as follows regardless of inputs: pc_enable = 0, ifid_enable = 0, idex_bubble = 1, pipe_advance = 0, wb_write_enable = 0, wb_write_address = 0.
- Reset mid-operation: all in-flight writers are discarded immediately and no write-back strobe occurs. After deassertion, the first edge behaves as from an empty pipeline.
- Hazard detect to stall: 0 cycles (combinational in the same cycle the instruction sits in ID).
- Dependent back-to-back writer/reader: the reader is held exactly 3 cycles and issues to EX on the 4th edge after the writer's EX entry.
- Simultaneous mem_busy and hazard: the freeze dominates. The cycle counts as neither a stall cycle nor an FSM transition.
- Writer and reader in the same instruction (e.g. rd = ra) is not a hazard against itself.

## Test plan

- Reset: hold reset low with id_valid = 1 and id_instruction = 0x03120. Required: pc_enable = 0, idex_bubble = 1, counters 0. Release reset: pc_enable = 1 next cycle.
- RAW stall: issue 0x03120 (r3 = r1 + r2), then 0x04300 (r4 = r3 + r0). Required: pc_enable low for exactly 3 cycles, stall_cycles = 3, stall_events = 1, wb_write_address = 3 with wb_write_enable on the cycle before the reader issues.
- Independent stream: issue 0x03120 then 0x14560. Required: no stall, stall_cycles = 0, write-backs to r3 then r4 on consecutive cycles.
- Store source check: issue 0x05120, then store 0xC5700 (reads r5, r7). Required: 3-cycle stall. Store 0xC7800 after the same writer: no stall, and the store never asserts wb_write_enable.
- Freeze: assert mem_busy for 4 cycles during an active stall. Required: scoreboard, state and counters unchanged, all enables 0. After release, the remaining stall cycles complete.
- Saturation with CNT_WIDTH = 2: force 5 hazard cycles. Required: stall_cycles stays at 3.
